// File: rtl/conv_pkg.sv
// Shared requantization constants, config struct and int8 saturation helper.
`ifndef CONV_PKG_SV
`define CONV_PKG_SV

// Select lane i of width w from a flat lane-packed vector.
`define CONV_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package conv_pkg;
  localparam int LANES      = 8;
  localparam int ACC_W      = 32;
  localparam int SCALE_W    = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int PROD_W     = ACC_W + SCALE_W + 1;  // acc * {0,scale}
  localparam int RND_W      = PROD_W + 1;           // headroom for round + bias
  localparam int INT8_MIN   = -128;
  localparam int INT8_MAX   = 127;

  typedef struct packed {
    logic [31:0]                     total_beats;
    logic [4:0]                      shift;
    logic [LANES-1:0][SCALE_W-1:0]   scale;
    logic [LANES-1:0][7:0]           bias;
  } cfg_t;

  function automatic logic [7:0] sat_int8(input logic signed [RND_W-1:0] v);
    if (v > RND_W'(INT8_MAX))      return 8'h7f;
    else if (v < RND_W'(INT8_MIN)) return 8'h80;
    else                           return v[7:0];
  endfunction
endpackage

`endif

// File: rtl/conv_result_requant_if.sv
// Packed int8 output stream towards the ConvOutput/DMA write path.
interface conv_result_requant_if;
  import conv_pkg::*;
  logic [LANES*8-1:0] mData;
  logic               mValid;
  logic               mReady;
  logic               mLast;
  modport master (output mData, mValid, mLast, input mReady);
  modport slave  (input mData, mValid, mLast, output mReady);
endinterface

// File: rtl/result_fifo.sv
// Sync FIFO with a registered head. The entry shown on dout still occupies its
// slot until popped, so full/empty cover every stored beat.
module result_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, nh;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the head slot in the same cycle, so full+pop still accepts.
  assign wr_en = push && (!full || pop);
  // Head index after this cycle's pop; a write this cycle is not visible yet.
  assign nh    = rd_ptr + (AW+1)'(pop && !empty);

  // Storage array, no reset needed.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;

  // Pointers and the registered head view.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0; rd_ptr <= '0; dout <= '0; dout_vld <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0; rd_ptr <= '0; dout <= '0; dout_vld <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= nh;
      dout_vld <= (nh != wr_ptr);
      dout     <= (nh != wr_ptr) ? mem[nh[AW-1:0]] : '0;
    end
endmodule

// File: rtl/conv_result_requant.sv
// Requantizes one row of int32 accumulators per beat to int8, packs it and
// buffers it behind a FIFO since the Tile upstream cannot stall.
module conv_result_requant
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              total_beats,
  input  logic [4:0]               shift,
  input  logic [LANES*SCALE_W-1:0] scale,
  input  logic [LANES*8-1:0]       bias,
  input  logic [LANES-1:0]         acc_valid,
  input  logic [LANES*ACC_W-1:0]   acc_data,
  conv_result_requant_if.master    m,
  output logic                     overflow,
  output logic                     busy
);
  localparam int STAGES = 2;  // registered stages ahead of the FIFO push

  cfg_t                          cfg;
  logic [31:0]                   in_cnt, out_cnt;
  logic                          take, push, last, pop, full, empty, fifo_vld;
  logic [STAGES:1]               vld_pipe;
  logic [LANES-1:0]              lv1, lv2;
  logic [LANES-1:0][PROD_W-1:0]  prod_d, prod_q;
  logic [LANES-1:0][RND_W-1:0]   r_d, r_q;
  logic [LANES-1:0][7:0]         byte3;
  logic signed [RND_W-1:0]       rnd;
  logic [64:0]                   fifo_dout;

  assign take = busy && (|acc_valid) && (in_cnt < cfg.total_beats);
  assign push = vld_pipe[STAGES];
  assign last = (out_cnt == cfg.total_beats - 32'd1);
  assign pop  = m.mValid && m.mReady;
  // Half-LSB rounding constant; zero when no shift is applied.
  assign rnd  = (cfg.shift == 5'd0) ? '0 : (RND_W'(1) << (cfg.shift - 5'd1));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [RND_W-1:0] pw;
    assign prod_d[i] = PROD_W'($signed(`CONV_LANE(acc_data, i, ACC_W)))
                     * PROD_W'($signed({1'b0, cfg.scale[i]}));
    assign pw        = RND_W'($signed(prod_q[i]));
    assign r_d[i]    = ((pw + rnd) >>> cfg.shift) + RND_W'($signed(cfg.bias[i]));
    assign byte3[i]  = lv2[i] ? sat_int8($signed(r_q[i])) : 8'h00;
  end

  // Layer configuration captured on start.
  always_ff @(posedge clk or negedge reset)
    if (!reset)     cfg <= '0;
    else if (start) cfg <= '{total_beats: total_beats, shift: shift,
                             scale: scale, bias: bias};

  // Requant pipeline: S1 multiply, S2 round/shift/bias; S3 is combinational.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld_pipe <= '0; lv1 <= '0; lv2 <= '0; prod_q <= '0; r_q <= '0;
    end else if (start) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], take};
      lv1      <= acc_valid;
      lv2      <= lv1;
      prod_q   <= prod_d;
      r_q      <= r_d;
    end

  // Beat counters, sticky overflow and layer busy.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_cnt <= '0; out_cnt <= '0; busy <= 1'b0; overflow <= 1'b0;
    end else if (start) begin
      in_cnt <= '0; out_cnt <= '0; busy <= 1'b1; overflow <= 1'b0;
    end else begin
      if (take) in_cnt <= in_cnt + 32'd1;
      // Dropped beats still advance out_cnt so the last tag stays aligned.
      if (push) out_cnt <= out_cnt + 32'd1;
      if (push && full && !(pop && !empty)) overflow <= 1'b1;
      if (pop && m.mLast) busy <= 1'b0;
    end

  result_fifo #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (start),
    .push     (push),
    .din      ({last, byte3}),
    .full     (full),
    .pop      (pop),
    .empty    (empty),
    .dout     (fifo_dout),
    .dout_vld (fifo_vld)
  );

  assign m.mData  = fifo_dout[63:0];
  assign m.mLast  = fifo_dout[64];
  assign m.mValid = fifo_vld;
endmodule

// File: tb/tb_conv_result_requant.sv
// Directed bench for conv_result_requant with an arithmetic reference model
// and a scoreboard checked on every output transfer.
module tb_conv_result_requant;
  import conv_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     start = 1'b0;
  logic [31:0]              total_beats = '0;
  logic [4:0]               shift = '0;
  logic [LANES*SCALE_W-1:0] scale = '0;
  logic [LANES*8-1:0]       bias = '0;
  logic [LANES-1:0]         acc_valid = '0;
  logic [LANES*ACC_W-1:0]   acc_data = '0;
  logic                     overflow, busy;

  conv_result_requant_if m();

  conv_result_requant dut (
    .clk(clk), .reset(reset), .start(start), .total_beats(total_beats),
    .shift(shift), .scale(scale), .bias(bias), .acc_valid(acc_valid),
    .acc_data(acc_data), .m(m), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [64:0] expq[$];
  int n_out = 0;
  logic [63:0] last_data = '0;
  logic last_last = 1'b0;

  // reference model state
  int m_total = 0, m_sent = 0, m_shift = 0;
  logic [LANES*SCALE_W-1:0] m_scale = '0;
  logic [LANES*8-1:0] m_bias = '0;

  // ready pattern: 0 always ready, 1 toggles every 3 cycles, 2 never ready
  int rdy_mode = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round-half-up of acc*scale/2^sh via floor division, plus bias, clamped.
  function automatic logic [7:0] ref_byte(longint acc, longint sc, int sh, longint b);
    longint p, d, q;
    p = acc * sc;
    if (sh == 0) q = p;
    else begin
      d = longint'(1) << sh;
      p = p + d / 2;
      q = p / d;
      if ((p % d != 0) && (p < 0)) q = q - 1;
    end
    q = q + b;
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
    return q[7:0];
  endfunction

  function automatic logic [LANES*ACC_W-1:0] mk(int b, int mul, int off);
    logic [LANES*ACC_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[32*i +: 32] = b * mul + i * 17 + off;
    return d;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int n);
    total_beats = n;
    start = 1'b1;
    m_total = n; m_sent = 0; m_shift = int'(shift); m_scale = scale; m_bias = bias;
    expq.delete();
    n_out = 0;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input logic [LANES-1:0] v, input logic [LANES*ACC_W-1:0] d, input bit keep);
    logic [63:0] e;
    e = '0;
    acc_valid = v;
    acc_data  = d;
    if (m_sent < m_total) begin
      for (int i = 0; i < LANES; i++)
        e[8*i +: 8] = v[i] ? ref_byte($signed(d[32*i +: 32]), m_scale[16*i +: 16], m_shift,
                                      $signed(m_bias[8*i +: 8])) : 8'h00;
      if (keep) expq.push_back({(m_sent == m_total - 1), e});
      m_sent++;
    end
    tick;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((expq.size() != 0 || m.mValid) && k < budget) begin tick; k++; end
    if (k >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats pending, required 0", expq.size());
    end
  endtask

  // downstream ready driver
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m.mReady = 1'b1;
      1:       m.mReady = ((cyc / 3) % 2) == 0;
      default: m.mReady = 1'b0;
    endcase
  end

  // scoreboard compare on every transfer, plus hold-while-stalled checks
  logic prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;
  always @(negedge clk) begin
    if (!reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", m.mValid, 1);
        chk("hold_data", {m.mLast, m.mData}, prev_beat);
      end
      if (m.mValid && m.mReady) begin
        n_out++;
        last_data = m.mData;
        last_last = m.mLast;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", {m.mLast, m.mData});
        end else chk("beat", {m.mLast, m.mData}, expq.pop_front());
      end
      prev_stall = m.mValid && !m.mReady;
      prev_beat  = {m.mLast, m.mData};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*ACC_W-1:0] d;
    int k;
    // reset state
    repeat (3) tick;
    chk("rst_mValid", m.mValid, 0);
    chk("rst_mLast", m.mLast, 0);
    chk("rst_mData", m.mData, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick;

    // identity: lane i = i-3
    scale = {LANES{16'd1}}; shift = 5'd0; bias = '0;
    do_start(1);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < LANES; i++) d[32*i +: 32] = i - 3;
    send(8'hFF, d, 1'b1);
    acc_valid = '0;
    k = 1;
    while (!m.mValid && k < 10) begin tick; k++; end
    chk("latency", k, 4);
    drain(50);
    chk("identity_data", last_data, 64'h04030201_00FFFEFD);
    chk("identity_last", last_last, 1);
    chk("identity_nout", n_out, 1);
    repeat (2) tick;
    chk("identity_busy_low", busy, 0);

    // rounding and saturation
    scale = {LANES{16'd3}}; shift = 5'd2; bias = '0; bias[8*3 +: 8] = 8'hFB;
    do_start(1);
    d[32*0 +: 32] = 5;     d[32*1 +: 32] = 1000; d[32*2 +: 32] = -1000;
    d[32*3 +: 32] = 5;     d[32*4 +: 32] = -5;   d[32*5 +: 32] = 6;
    d[32*6 +: 32] = 2;     d[32*7 +: 32] = 0;
    send(8'hFF, d, 1'b1);
    acc_valid = '0;
    drain(50);
    chk("round_sat_data", last_data, 64'h000205FC_FF807F04);
    chk("round_sat_last", last_last, 1);

    // backpressure: 40 beats, ready toggling every 3 cycles
    scale = {LANES{16'd1}}; shift = 5'd0; bias = '0;
    rdy_mode = 1;
    do_start(40);
    for (int b = 0; b < 40; b++) send(8'hFF, mk(b, 13, -150), 1'b1);
    acc_valid = '0;
    drain(500);
    chk("bp_nout", n_out, 40);
    chk("bp_last", last_last, 1);
    chk("bp_overflow", overflow, 0);
    rdy_mode = 0;
    repeat (2) tick;

    // overflow: DEPTH+4 beats into a stalled output
    scale = {LANES{16'd2}}; shift = 5'd1; bias = {LANES{8'd3}};
    rdy_mode = 2;
    do_start(100);
    for (int b = 0; b < FIFO_DEPTH + 4; b++) send(8'hFF, mk(b, 5, -40), b < FIFO_DEPTH);
    acc_valid = '0;
    repeat (5) tick;
    chk("ovf_flag", overflow, 1);
    rdy_mode = 0;
    drain(400);
    chk("ovf_nout", n_out, FIFO_DEPTH);
    chk("ovf_no_last", last_last, 0);
    chk("ovf_busy", busy, 1);

    // partial lanes and an extra beat beyond total_beats
    scale = {LANES{16'd1}}; shift = 5'd0; bias = {LANES{8'd7}};
    do_start(2);
    for (int b = 0; b < 3; b++) send(8'h0F, mk(b, 11, 20), 1'b1);
    acc_valid = '0;
    drain(50);
    repeat (4) tick;
    chk("partial_nout", n_out, 2);
    chk("partial_upper", last_data[63:32], 0);
    chk("partial_last", last_last, 1);

    // abort by reset mid-layer, then a fresh layer
    scale = {LANES{16'd1}}; shift = 5'd3; bias = {LANES{8'hFE}};
    do_start(20);
    for (int b = 0; b < 10; b++) send(8'hFF, mk(b, 40, -300), 1'b1);
    acc_valid = '0;
    reset = 1'b0;
    #1;
    chk("abort_mValid", m.mValid, 0);
    chk("abort_busy", busy, 0);
    expq.delete();
    n_out = 0;
    repeat (3) tick;
    reset = 1'b1;
    repeat (5) tick;
    chk("abort_idle_mValid", m.mValid, 0);
    chk("abort_idle_nout", n_out, 0);
    do_start(5);
    for (int b = 0; b < 5; b++) send(8'hFF, mk(b, 29, -60), 1'b1);
    acc_valid = '0;
    drain(100);
    chk("abort_restart_nout", n_out, 5);
    chk("abort_restart_last", last_last, 1);
    repeat (2) tick;
    chk("abort_restart_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
